spmv_mem_arbiter: RTL

Shares one Convey-style memory port between NUM_PORTS spmv_pe memory interfaces.
- Arbitrates load and store requests round-robin into a single registered output stage.
- Extends each load tag with the requester ID, and uses that ID to route each response back to its requester.
- Sits between the PE array and the MC interface in the SpMV top level.

---
 rtl/spmv_mem_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/spmv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spmv_mem_arbiter
// Purpose  : Round-robin share of one memory port between NUM_PORTS SpMV PEs;
//            load tags carry the requester ID for response routing.
//            Optional perf counters: define SPMV_MEM_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spmv_mem_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ID_W      = 2,
    parameter int TAG_W     = 3,
    parameter int ADDR_W    = 48
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        pe_req_ld,
    input  logic [NUM_PORTS-1:0]        pe_req_st,
    input  logic [NUM_PORTS*ADDR_W-1:0] pe_req_addr,
    input  logic [NUM_PORTS*64-1:0]     pe_req_d_or_tag,
    output logic [NUM_PORTS-1:0]        pe_req_stall,
    output logic [NUM_PORTS-1:0]        pe_rsp_push,
    output logic [TAG_W-1:0]            pe_rsp_tag,
    output logic [63:0]                 pe_rsp_q,
    input  logic [NUM_PORTS-1:0]        pe_rsp_stall,
    output logic                        mem_req_ld,
    output logic                        mem_req_st,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic [63:0]                 mem_req_d_or_tag,
    input  logic                        mem_req_stall,
    input  logic                        mem_rsp_push,
    input  logic [ID_W+TAG_W-1:0]       mem_rsp_tag,
    input  logic [63:0]                 mem_rsp_q,
    output logic                        mem_rsp_stall
);

    localparam int c_PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [c_PW-1:0]      r_ptr;
    logic                 r_full;
    logic                 r_ld;
    logic                 r_st;
    logic [ADDR_W-1:0]    r_addr;
    logic [63:0]          r_data;
    logic                 r_bad_id;

    logic [NUM_PORTS-1:0] w_elig;
    logic                 w_free;
    logic                 w_gnt_vld;
    logic [c_PW-1:0]      w_gnt_idx;
    logic                 w_sel_ld;
    logic                 w_sel_st;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [63:0]          w_sel_d;
    logic [TAG_W-1:0]     w_sel_tag;
    logic [ID_W-1:0]      w_rsp_id;

    // A load whose response path is backpressured must not be issued.
    assign w_elig = (pe_req_ld & ~pe_rsp_stall) | pe_req_st;
    assign w_free = ~r_full | ~mem_req_stall;

    // Lowest eligible index at or above the pointer wins, otherwise lowest overall.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = c_PW'(i);
            end
        end
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_elig[i] && (i >= int'(r_ptr))) begin
                w_gnt_idx = c_PW'(i);
            end
        end
        if (rst || !w_free) begin
            w_gnt_vld = 1'b0;
        end
    end

    always_comb begin
        w_sel_ld   = 1'b0;
        w_sel_st   = 1'b0;
        w_sel_addr = '0;
        w_sel_d    = '0;
        w_sel_tag  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (int'(w_gnt_idx) == i) begin
                w_sel_ld   = pe_req_ld[i];
                w_sel_st   = pe_req_st[i];
                w_sel_addr = pe_req_addr[i*ADDR_W +: ADDR_W];
                w_sel_d    = pe_req_d_or_tag[i*64 +: 64];
                w_sel_tag  = pe_req_d_or_tag[i*64 +: TAG_W];
            end
        end
    end

    always_comb begin
        pe_req_stall = '1;
        if (w_gnt_vld) begin
            pe_req_stall[w_gnt_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_full <= 1'b0;
            r_ld   <= 1'b0;
            r_st   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_free) begin
            if (w_gnt_vld) begin
                r_full <= 1'b1;
                r_ld   <= w_sel_ld;
                r_st   <= w_sel_st;
                r_addr <= w_sel_addr;
                r_data <= w_sel_st ? w_sel_d
                                   : {{(64-ID_W-TAG_W){1'b0}}, ID_W'(w_gnt_idx), w_sel_tag};
                r_ptr  <= (int'(w_gnt_idx) == NUM_PORTS - 1) ? '0 : w_gnt_idx + c_PW'(1);
            end else begin
                r_full <= 1'b0;
                r_ld   <= 1'b0;
                r_st   <= 1'b0;
            end
        end
    end

    assign mem_req_ld       = r_ld;
    assign mem_req_st       = r_st;
    assign mem_req_addr     = r_addr;
    assign mem_req_d_or_tag = r_data;

    assign w_rsp_id = mem_rsp_tag[ID_W+TAG_W-1:TAG_W];

    always_comb begin
        pe_rsp_push = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!rst && mem_rsp_push && (int'(w_rsp_id) == i)) begin
                pe_rsp_push[i] = 1'b1;
            end
        end
    end

    assign pe_rsp_tag    = rst ? '0 : mem_rsp_tag[TAG_W-1:0];
    assign pe_rsp_q      = rst ? '0 : mem_rsp_q;
    assign mem_rsp_stall = ~rst & (|pe_rsp_stall);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bad_id <= 1'b0;
        end else if (mem_rsp_push && (int'(w_rsp_id) >= NUM_PORTS)) begin
            r_bad_id <= 1'b1;
        end
    end

`ifdef SPMV_MEM_ARB_PERF_EN
    logic [63:0] grant_count [NUM_PORTS];
    logic [63:0] stall_count [NUM_PORTS];
    logic [63:0] mem_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                grant_count[i] <= '0;
                stall_count[i] <= '0;
            end
            mem_stall_count <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if ((pe_req_ld[i] | pe_req_st[i]) && !pe_req_stall[i]) begin
                    grant_count[i] <= grant_count[i] + 64'd1;
                end
                if ((pe_req_ld[i] | pe_req_st[i]) && pe_req_stall[i]) begin
                    stall_count[i] <= stall_count[i] + 64'd1;
                end
            end
            if (r_full && mem_req_stall) begin
                mem_stall_count <= mem_stall_count + 64'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
